img_to_uart: RTL

- Streams a stored 8-bit grayscale image from the FPGA back to the laptop over UART. Used to return the downscaled pyramid image for host-side debug.
- Sits between the image register in top and uart_tcvr. It mirrors uart_to_img, which handles the receive direction.
- Reads pixels row-major through an index port and frames them as: sync byte, height, width, pixels, checksum.
- Honours host flow control on uart_cts.

---
 rtl/img_to_uart_pkg.sv | 36 +++
 rtl/img_to_uart_if.sv | 24 ++
 rtl/img_to_uart_raster_ctr.sv | 53 +++++
 rtl/img_to_uart.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/img_to_uart_pkg.sv
// Shared types for the UART image-return path: FSM states, frame phases and framing constants.
// Default image dimensions fall back to a small laptop frame when top does not define them.
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 64
`endif
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 64
`endif

package vj_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_CTS,
        SEND,
        NEXT,
        DONE
    } tx_state_e;

    typedef enum logic [2:0] {
        SYNC,
        HGT,
        WID,
        PIX,
        SUM
    } phase_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Dimensions are sent minus one so that 256 still fits in a byte.
    function automatic logic [7:0] dim_byte(input int unsigned n);
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/img_to_uart_if.sv
// Bundle between img_to_uart and its neighbours: control strobes, pixel read port and UART byte handshake.
// master = the frame sender, slave = the image register / uart_tcvr side.
interface img_to_uart_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] row_idx;
    logic [7:0] col_idx;
    logic [7:0] pixel_data;
    logic       uart_cts;
    logic       uart_data_sent;
    logic       send_uart_data;
    logic [7:0] uart_data_tx;

    modport master (
        input  start, pixel_data, uart_cts, uart_data_sent,
        output busy, done, row_idx, col_idx, send_uart_data, uart_data_tx
    );

    modport slave (
        output start, pixel_data, uart_cts, uart_data_sent,
        input  busy, done, row_idx, col_idx, send_uart_data, uart_data_tx
    );
endinterface

// File: rtl/img_to_uart_raster_ctr.sv
// Row-major raster position counter with clear, enable and a last-pixel flag.
// Holds at the final pixel instead of wrapping so callers can read the end position.
module img_raster_ctr #(
    parameter int unsigned HEIGHT = 1,
    parameter int unsigned WIDTH  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       last
);
    import vj_uart_pkg::*;

    localparam logic [7:0] ROW_MAX = dim_byte(HEIGHT);
    localparam logic [7:0] COL_MAX = dim_byte(WIDTH);

    logic [7:0] row_q, row_d;
    logic [7:0] col_q, col_d;

    assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign row  = row_q;
    assign col  = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = 8'd0;
            col_d = 8'd0;
        end else if (en && !last) begin
            if (col_q == COL_MAX) begin
                col_d = 8'd0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= 8'd0;
            col_q <= 8'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/img_to_uart.sv
// Frames a stored grayscale image as SYNC, H-1, W-1, pixels, checksum and hands it byte by byte to uart_tcvr.
// Each byte goes LOAD -> WAIT_CTS -> SEND -> NEXT; flow control is only checked before a byte starts.
module img_to_uart
    import vj_uart_pkg::*;
#(
    parameter int unsigned IMG_HEIGHT = `LAPTOP_HEIGHT,
    parameter int unsigned IMG_WIDTH  = `LAPTOP_WIDTH,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    img_to_uart_if.master      bus
);

    tx_state_e  state_q, state_d;
    phase_e     phase_q, phase_d;
    logic [7:0] checksum_q, checksum_d;
    logic [7:0] tx_q, tx_d;
    logic       send_q, send_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       ctr_clr;
    logic       ctr_en;
    logic       last_pix;
    logic [7:0] row_w;
    logic [7:0] col_w;
    logic [7:0] phase_byte;

    img_raster_ctr #(
        .HEIGHT (IMG_HEIGHT),
        .WIDTH  (IMG_WIDTH)
    ) u_raster (
        .clk   (clock),
        .rst_n (reset_n),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .row   (row_w),
        .col   (col_w),
        .last  (last_pix)
    );

    // Indices are registered, so pixel_data is valid for the whole LOAD cycle.
    always_comb begin
        phase_byte = 8'd0;
        case (phase_q)
            SYNC:    phase_byte = SYNC_BYTE;
            HGT:     phase_byte = dim_byte(IMG_HEIGHT);
            WID:     phase_byte = dim_byte(IMG_WIDTH);
            PIX:     phase_byte = bus.pixel_data;
            SUM:     phase_byte = checksum_q;
            default: phase_byte = 8'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        checksum_d = checksum_q;
        tx_d       = tx_q;
        send_d     = send_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ctr_clr    = 1'b0;
        ctr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = LOAD;
                    phase_d    = SYNC;
                    checksum_d = 8'd0;
                    busy_d     = 1'b1;
                    ctr_clr    = 1'b1;
                end
            end
            LOAD: begin
                tx_d = phase_byte;
                if (phase_q == PIX) begin
                    checksum_d = checksum_q + bus.pixel_data;
                end
                state_d = WAIT_CTS;
            end
            WAIT_CTS: begin
                if (bus.uart_cts) begin
                    state_d = SEND;
                    send_d  = 1'b1;
                end
            end
            SEND: begin
                // A started byte always completes, regardless of uart_cts.
                if (bus.uart_data_sent) begin
                    state_d = NEXT;
                    send_d  = 1'b0;
                end
            end
            NEXT: begin
                state_d = LOAD;
                case (phase_q)
                    SYNC: phase_d = HGT;
                    HGT:  phase_d = WID;
                    WID:  phase_d = PIX;
                    PIX: begin
                        if (last_pix) begin
                            phase_d = SUM;
                        end else begin
                            ctr_en = 1'b1;
                        end
                    end
                    SUM: begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                    default: phase_d = SYNC;
                endcase
            end
            DONE: begin
                busy_d  = 1'b0;
                ctr_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            phase_q    <= SYNC;
            checksum_q <= 8'd0;
            tx_q       <= 8'd0;
            send_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            checksum_q <= checksum_d;
            tx_q       <= tx_d;
            send_q     <= send_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.row_idx        = row_w;
    assign bus.col_idx        = col_w;
    assign bus.send_uart_data = send_q;
    assign bus.uart_data_tx   = tx_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule
